// File: rtl/addsub_requester.sv
// addsub_requester - command/response front end for an external combinational adder_subtractor
// Registers operands, waits one settle cycle, captures the result and holds it until consumed.
module addsub_requester #(
  parameter int WIDTH     = 4,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [WIDTH-1:0]     cmd_a,
  input  logic [WIDTH-1:0]     cmd_b,
  input  logic                 cmd_sub,
  input  logic                 cmd_acc,
  input  logic                 cmd_clr,
  output logic [WIDTH-1:0]     as_a,
  output logic [WIDTH-1:0]     as_b,
  output logic                 as_sub,
  input  logic [WIDTH-1:0]     as_result,
  input  logic                 as_carry,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [WIDTH-1:0]     rsp_result,
  output logic                 rsp_carry,
  output logic [WIDTH-1:0]     acc,
  output logic [CNT_WIDTH-1:0] op_count
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0] state;

  assign cmd_ready = (state == IDLE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      as_a       <= '0;
      as_b       <= '0;
      as_sub     <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_carry  <= 1'b0;
      acc        <= '0;
      op_count   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            // Accumulator mode substitutes acc (or zero on clear) for operand A.
            as_a   <= cmd_acc ? (cmd_clr ? '0 : acc) : cmd_a;
            as_b   <= cmd_b;
            as_sub <= cmd_sub;
            state  <= EXEC;
          end
        end
        EXEC: begin
          rsp_result <= as_result;
          rsp_carry  <= as_carry;
          acc        <= as_result;
          rsp_valid  <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            op_count  <= op_count + CNT_WIDTH'(1);
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_requester.sv
// tb/tb_addsub_requester.sv - scoreboard bench for addsub_requester with a behavioural adder_subtractor
module tb_addsub_requester;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [3:0] cmd_a = '0;
  logic [3:0] cmd_b = '0;
  logic       cmd_sub = 1'b0;
  logic       cmd_acc = 1'b0;
  logic       cmd_clr = 1'b0;
  logic [3:0] as_a, as_b;
  logic       as_sub;
  logic [3:0] as_result;
  logic       as_carry;
  logic       rsp_valid;
  logic       rsp_ready = 1'b1;
  logic [3:0] rsp_result;
  logic       rsp_carry;
  logic [3:0] acc;
  logic [1:0] op_count;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       sub;
    logic [3:0] res;
    logic       c;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  // External adder_subtractor: subtract is a + ~b + 1, carry=1 means no borrow.
  logic [4:0] sum;
  assign sum = as_sub ? ({1'b0, as_a} + {1'b0, ~as_b} + 5'd1) : ({1'b0, as_a} + {1'b0, as_b});
  assign as_result = sum[3:0];
  assign as_carry  = sum[4];

  addsub_requester #(.WIDTH(4), .CNT_WIDTH(2)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sub(cmd_sub), .cmd_acc(cmd_acc), .cmd_clr(cmd_clr),
    .as_a(as_a), .as_b(as_b), .as_sub(as_sub),
    .as_result(as_result), .as_carry(as_carry),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_carry(rsp_carry),
    .acc(acc), .op_count(op_count)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops on every response handshake and tracks expected op_count.
  int exp_cnt = 0;
  always @(negedge clk) begin
    if (rst) begin
      exp_cnt = 0;
    end else if (rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_rsp", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_result", rsp_result, e.res);
        chk("rsp_carry", rsp_carry, e.c);
        chk("acc", acc, e.res);
        chk("as_a", as_a, e.a);
        chk("as_b", as_b, e.b);
        chk("as_sub", as_sub, e.sub);
        chk("op_count_pre", op_count, exp_cnt % 4);
        exp_cnt = exp_cnt + 1;
      end
    end
  end

  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic sub,
                      input logic accm, input logic clr,
                      input logic [3:0] ea, input logic [3:0] eres, input logic ec,
                      input bit wait_done);
    int n;
    exp_t e;
    @(negedge clk);
    cmd_a = a; cmd_b = b; cmd_sub = sub; cmd_acc = accm; cmd_clr = clr;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("accept", cmd_ready, 1);
    e.a = ea; e.b = b; e.sub = sub; e.res = eres; e.c = ec;
    sb.push_back(e);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    chk("latency_rsp_valid", rsp_valid, 1);
    if (wait_done) begin
      n = 0;
      while (rsp_valid && n < 20) begin
        @(posedge clk); #1;
        n++;
      end
      chk("rsp_done", rsp_valid, 0);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("ready_in_reset", cmd_ready, 0);
    rst = 1'b0;
    #1;
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_acc", acc, 0);
    chk("reset_op_count", op_count, 0);
    chk("reset_as", {as_a, as_b, as_sub}, 0);
    chk("reset_rsp", {rsp_result, rsp_carry}, 0);
    chk("ready_after_reset", cmd_ready, 1);

    // Plain add and subtract
    send(4'd5, 4'd3, 1'b0, 1'b0, 1'b0, 4'd5, 4'd8, 1'b0, 1);
    send(4'd3, 4'd8, 1'b1, 1'b0, 1'b0, 4'd3, 4'b1011, 1'b0, 1);
    send(4'd15, 4'd0, 1'b1, 1'b0, 1'b0, 4'd15, 4'd15, 1'b1, 1);
    // Accumulator chain
    send(4'd9, 4'd15, 1'b0, 1'b1, 1'b1, 4'd0, 4'd15, 1'b0, 1);
    send(4'd9, 4'd15, 1'b0, 1'b1, 1'b0, 4'd15, 4'd14, 1'b1, 1);
    send(4'd9, 4'd1, 1'b1, 1'b1, 1'b0, 4'd14, 4'd13, 1'b1, 1);
    chk("acc_chain_end", acc, 13);
    chk("op_count_6", op_count, 2);

    // Backpressure: response and operands must hold, commands ignored
    rsp_ready = 1'b0;
    send(4'd6, 4'd9, 1'b0, 1'b0, 1'b0, 4'd6, 4'd15, 1'b0, 0);
    cmd_a = 4'd3; cmd_b = 4'd3; cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_result", rsp_result, 15);
      chk("bp_as", {as_a, as_b}, {4'd6, 4'd9});
      chk("bp_cmd_ready", cmd_ready, 0);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_released", rsp_valid, 0);
    chk("bp_op_count", op_count, 3);
    chk("bp_cmd_ready", cmd_ready, 1);

    // Reset while in EXEC aborts the op
    @(negedge clk);
    cmd_a = 4'd2; cmd_b = 4'd2; cmd_sub = 1'b0; cmd_acc = 1'b0; cmd_clr = 1'b0;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_rsp_valid", rsp_valid, 0);
    chk("rst_mid_acc", acc, 0);
    chk("rst_mid_op_count", op_count, 0);
    chk("rst_mid_ready", cmd_ready, 0);
    rst = 1'b0;
    #1;
    chk("rst_mid_ready_after", cmd_ready, 1);

    // Five ops after reset: counter wraps 1,2,3,0,1
    send(4'd1, 4'd1, 1'b0, 1'b0, 1'b0, 4'd1, 4'd2, 1'b0, 1);
    chk("wrap_1", op_count, 1);
    send(4'd7, 4'd9, 1'b0, 1'b0, 1'b1, 4'd7, 4'd0, 1'b1, 1);
    chk("wrap_2", op_count, 2);
    send(4'd9, 4'd4, 1'b1, 1'b0, 1'b0, 4'd9, 4'd5, 1'b1, 1);
    chk("wrap_3", op_count, 3);
    send(4'd0, 4'd3, 1'b0, 1'b1, 1'b0, 4'd5, 4'd8, 1'b0, 1);
    chk("wrap_0", op_count, 0);
    send(4'd7, 4'd2, 1'b1, 1'b1, 1'b1, 4'd0, 4'd14, 1'b0, 1);
    chk("wrap_1b", op_count, 1);

    repeat (2) @(posedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
